// File: rtl/cpu_controller.sv
// Eight-phase sequencer for the Simple RISC CPU.
// Decodes control strobes from the phase counter, halt flag, opcode and zero.
module cpu_controller #(
    parameter logic [2:0] OP_HLT = 3'd0,
    parameter logic [2:0] OP_SKZ = 3'd1,
    parameter logic [2:0] OP_ADD = 3'd2,
    parameter logic [2:0] OP_AND = 3'd3,
    parameter logic [2:0] OP_XOR = 3'd4,
    parameter logic [2:0] OP_LDA = 3'd5,
    parameter logic [2:0] OP_STO = 3'd6,
    parameter logic [2:0] OP_JMP = 3'd7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       sel,
    output logic       rd,
    output logic       wr,
    output logic       ld_ir,
    output logic       ld_ac,
    output logic       ld_pc,
    output logic       inc_pc,
    output logic       data_e,
    output logic       halt,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    phase_t r_phase;
    logic   r_halted;

    logic w_aluop;
    logic w_hlt;
    logic w_skz;
    logic w_sto;
    logic w_jmp;

    assign w_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                     (opcode == OP_XOR) || (opcode == OP_LDA);
    assign w_hlt   = (opcode == OP_HLT);
    assign w_skz   = (opcode == OP_SKZ);
    assign w_sto   = (opcode == OP_STO);
    assign w_jmp   = (opcode == OP_JMP);

    // Halting freezes the counter at OP_ADDR until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase  <= INST_ADDR;
            r_halted <= 1'b0;
        end else if (r_halted) begin
            r_phase  <= OP_ADDR;
        end else if (r_phase == OP_ADDR && w_hlt) begin
            r_halted <= 1'b1;
        end else begin
            r_phase  <= phase_t'(r_phase + 3'd1);
        end
    end

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        ld_ir  = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        inc_pc = 1'b0;
        data_e = 1'b0;
        halt   = 1'b0;
        if (r_halted) begin
            halt = 1'b1;
        end else begin
            unique case (r_phase)
                INST_ADDR: begin
                    sel = 1'b1;
                end
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = w_hlt;
                end
                OP_FETCH: begin
                    rd = w_aluop;
                end
                ALU_OP: begin
                    rd     = w_aluop;
                    inc_pc = w_skz && zero;
                    ld_pc  = w_jmp;
                    data_e = w_sto;
                end
                STORE: begin
                    rd     = w_aluop;
                    ld_ac  = w_aluop;
                    ld_pc  = w_jmp;
                    wr     = w_sto;
                    data_e = w_sto;
                end
            endcase
        end
    end

    assign phase = r_phase;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed vector bench for cpu_controller.
// Outputs are packed as {sel,rd,ld_ir,inc_pc,ld_ac,ld_pc,wr,data_e,halt}.
module tb_cpu_controller;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic [2:0] opcode = 3'd0;
    logic       zero   = 1'b0;
    logic       sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt;
    logic [2:0] phase;
    logic [8:0] w_out;

    cpu_controller dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .zero   (zero),
        .sel    (sel),
        .rd     (rd),
        .wr     (wr),
        .ld_ir  (ld_ir),
        .ld_ac  (ld_ac),
        .ld_pc  (ld_pc),
        .inc_pc (inc_pc),
        .data_e (data_e),
        .halt   (halt),
        .phase  (phase)
    );

    assign w_out = {sel, rd, ld_ir, inc_pc, ld_ac, ld_pc, wr, data_e, halt};

    always #5 clk = ~clk;

    localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2;
    localparam logic [2:0] LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

    localparam logic [8:0] P0  = 9'b100000000;
    localparam logic [8:0] P1  = 9'b110000000;
    localparam logic [8:0] P23 = 9'b111000000;
    localparam logic [8:0] P4  = 9'b000100000;
    localparam logic [8:0] NONE = 9'b000000000;
    localparam logic [8:0] RDO  = 9'b010000000;
    localparam logic [8:0] RDAC = 9'b010010000;
    localparam logic [8:0] DE   = 9'b000000010;
    localparam logic [8:0] WRDE = 9'b000000110;
    localparam logic [8:0] INC  = 9'b000100000;
    localparam logic [8:0] LDPC = 9'b000001000;
    localparam logic [8:0] H4   = 9'b000100001;
    localparam logic [8:0] HOLD = 9'b000000001;

    typedef struct {
        logic       r;
        logic [2:0] op;
        logic       z;
        logic [2:0] ph;
        logic [8:0] ex;
    } vec_t;

    vec_t tv[$];
    int   n_vec = 0;
    int   n_bad = 0;
    logic watch = 1'b0;
    logic seen  = 1'b0;

    always @(ld_ac) if (watch && ld_ac) seen = 1'b1;

    task automatic push(input logic r, input logic [2:0] op, input logic z,
                        input logic [2:0] ph, input logic [8:0] ex);
        vec_t v;
        v.r = r; v.op = op; v.z = z; v.ph = ph; v.ex = ex;
        tv.push_back(v);
    endtask

    task automatic instr(input logic [2:0] op, input logic z,
                         input logic [8:0] e5, input logic [8:0] e6,
                         input logic [8:0] e7);
        push(1'b0, op, z, 3'd0, P0);
        push(1'b0, op, z, 3'd1, P1);
        push(1'b0, op, z, 3'd2, P23);
        push(1'b0, op, z, 3'd3, P23);
        push(1'b0, op, z, 3'd4, P4);
        push(1'b0, op, z, 3'd5, e5);
        push(1'b0, op, z, 3'd6, e6);
        push(1'b0, op, z, 3'd7, e7);
    endtask

    task automatic chk(input string nm, input int idx,
                       input logic [8:0] ex, input logic [2:0] ph);
        n_vec++;
        if ({w_out, phase} !== {ex, ph}) begin
            n_bad++;
            $display("FAIL %s[%0d]: outs=%b phase=%0d, want outs=%b phase=%0d",
                     nm, idx, w_out, phase, ex, ph);
        end
        n_vec++;
        if ((rd & wr) !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_wr_excl %s[%0d]: rd=%b wr=%b, want not both 1",
                     nm, idx, rd, wr);
        end
    endtask

    initial begin
        push(1'b1, LDA, 1'b0, 3'd0, P0);
        instr(LDA, 1'b0, RDO, RDO, RDAC);
        instr(STO, 1'b0, NONE, DE, WRDE);
        instr(SKZ, 1'b1, NONE, INC, NONE);
        instr(SKZ, 1'b0, NONE, NONE, NONE);
        instr(JMP, 1'b0, NONE, LDPC, LDPC);
        instr(ADD, 1'b1, RDO, RDO, RDAC);
        push(1'b0, HLT, 1'b0, 3'd0, P0);
        push(1'b0, HLT, 1'b0, 3'd1, P1);
        push(1'b0, HLT, 1'b0, 3'd2, P23);
        push(1'b0, HLT, 1'b0, 3'd3, P23);
        push(1'b0, HLT, 1'b0, 3'd4, H4);
        for (int k = 0; k < 11; k++) push(1'b0, HLT, 1'b0, 3'd4, HOLD);
        push(1'b1, HLT, 1'b0, 3'd0, P0);
        instr(LDA, 1'b0, RDO, RDO, RDAC);

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            rst    = tv[i].r;
            opcode = tv[i].op;
            zero   = tv[i].z;
            #1;
            chk("vec", i, tv[i].ex, tv[i].ph);
        end

        @(negedge clk);
        rst    = 1'b1;
        opcode = ADD;
        zero   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) @(negedge clk);
        #1;
        chk("add_ph6", 0, RDO, 3'd6);
        watch = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst", 0, P0, 3'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_release", 0, P0, 3'd0);
        @(negedge clk);
        #1;
        chk("resume", 0, P1, 3'd1);
        watch = 1'b0;
        n_vec++;
        if (seen !== 1'b0) begin
            n_bad++;
            $display("FAIL no_ld_ac: ld_ac seen=%b, want 0", seen);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
